// File: rtl/pulse_pkg.sv
// ============================================================================
// Module      : pulse_pkg
// Description : Shared definitions for the pulse pacer: FSM state encoding,
//               default parameter values and the gap-counter load helper.
// Contents    : ST_* state constants, pulse_state_e enum, MIN_GAP_DEF,
//               CNT_W_DEF, GAP_W, gap_load().
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_pkg;

  // Default pacing: rising edges at least MIN_GAP_DEF cycles apart,
  // pending-event counter CNT_W_DEF bits wide.
  localparam int MIN_GAP_DEF = 10;
  localparam int CNT_W_DEF   = 4;

  // Gap counter width; MIN_GAP is limited to 255 so 8 bits always suffice.
  localparam int GAP_W = 8;

  // FSM state encoding kept as plain constants for tools and scripts that
  // expect fixed codes; the enum below is built from the same values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    PULSE = ST_PULSE,
    GAP   = ST_GAP
  } pulse_state_e;

  // Value loaded into the gap counter when entering GAP. PULSE takes one
  // cycle and the counter-equals-zero cycle is the last GAP cycle, so
  // loading MIN_GAP-2 puts consecutive PULSE states exactly MIN_GAP apart.
  function automatic logic [GAP_W-1:0] gap_load(input int min_gap);
    return GAP_W'(min_gap - 2);
  endfunction

endpackage : pulse_pkg

`default_nettype wire

// File: rtl/sat_updown_cnt.sv
// ============================================================================
// Module      : sat_updown_cnt
// Description : Saturating up/down counter with synchronous clear. Counts up
//               on i_inc, down on i_dec, holds when both or neither are set,
//               and never wraps past zero or the all-ones maximum.
// Ports       : clk       - clock
//               rst_n     - synchronous active-low reset (count -> 0)
//               i_inc     - increment request
//               i_dec     - decrement request
//               i_clr     - synchronous clear, overrides inc/dec
//               o_cnt     - registered count
//               o_cnt_nxt - value o_cnt takes at the next edge
//               o_sat     - o_cnt is at its maximum
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_updown_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_cnt_nxt,
  output logic             o_sat
);

  localparam logic [WIDTH-1:0] c_cnt_max  = '1;
  localparam logic [WIDTH-1:0] c_cnt_zero = '0;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = c_cnt_zero;
    end else if (i_inc && !i_dec && (r_cnt != c_cnt_max)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (!i_inc && i_dec && (r_cnt != c_cnt_zero)) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= c_cnt_zero;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;
  assign o_sat     = (r_cnt == c_cnt_max);

endmodule : sat_updown_cnt

`default_nettype wire

// File: rtl/pulse_pacer.sv
// ============================================================================
// Module      : pulse_pacer
// Description : Turns a stream of single-cycle event requests into
//               single-cycle pulses on sig_a spaced at least MIN_GAP cycles
//               apart, so a fast-to-slow pulse synchronizer downstream never
//               sees two pulses too close together. Events arriving faster
//               than that are queued in a saturating counter; overflow is
//               recorded in a sticky flag.
// Ports       : clk      - clock
//               rst_n    - synchronous active-low reset
//               evt_in   - event request, one event per high cycle
//               flush    - clear pending events and overflow flag
//               sig_a    - registered pulse, one per accepted event
//               pend_cnt - events accepted but not yet emitted
//               busy     - FSM not idle or events pending (registered)
//               ovf      - sticky: an event was dropped at saturation
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_pacer
  import pulse_pkg::*;
#(
  parameter int MIN_GAP = MIN_GAP_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt_in,
  input  logic             flush,
  output logic             sig_a,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             busy,
  output logic             ovf
);

  localparam logic [GAP_W-1:0] c_gap_load = gap_load(MIN_GAP);
  localparam logic [GAP_W-1:0] c_gap_zero = '0;
  localparam logic [CNT_W-1:0] c_pend_zero = '0;

  pulse_state_e     r_state;
  pulse_state_e     w_state_nxt;
  logic [GAP_W-1:0] r_gap;
  logic             r_sig_a;
  logic             r_ovf;
  logic             r_busy;

  logic [CNT_W-1:0] w_pend;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_pend_sat;
  logic             w_avail;
  logic             w_gap_done;
  logic             w_launch;

  // An event is available to launch if one is queued or one arrives this
  // cycle. A flush discards both, so nothing launches in a flush cycle.
  assign w_avail    = !flush && ((w_pend != c_pend_zero) || evt_in);
  assign w_gap_done = (r_gap == c_gap_zero);

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_avail) begin
          w_state_nxt = PULSE;
          w_launch    = 1'b1;
        end
      end
      PULSE: begin
        w_state_nxt = GAP;
      end
      GAP: begin
        if (w_gap_done) begin
          if (w_avail) begin
            w_state_nxt = PULSE;
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Every arriving event counts up and every launch counts down. When a
  // launch is fed by the same-cycle event with nothing queued, inc and dec
  // cancel and the count stays at zero. Flush clears with priority.
  sat_updown_cnt #(
    .WIDTH (CNT_W)
  ) u_pend_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (evt_in),
    .i_dec     (w_launch),
    .i_clr     (flush),
    .o_cnt     (w_pend),
    .o_cnt_nxt (w_pend_nxt),
    .o_sat     (w_pend_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gap   <= c_gap_zero;
      r_sig_a <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == PULSE) begin
        r_gap <= c_gap_load;
      end else if ((r_state == GAP) && !w_gap_done) begin
        r_gap <= r_gap - 1'b1;
      end

      // sig_a is high exactly in the cycle the FSM sits in PULSE.
      r_sig_a <= w_launch;

      // An event is dropped only when the counter is full and no launch
      // frees a slot in the same cycle.
      if (flush) begin
        r_ovf <= 1'b0;
      end else if (evt_in && w_pend_sat && !w_launch) begin
        r_ovf <= 1'b1;
      end

      // Registered from next-state values so busy lines up with the
      // registered state and pend_cnt.
      r_busy <= (w_state_nxt != IDLE) || (w_pend_nxt != c_pend_zero);
    end
  end

  assign sig_a    = r_sig_a;
  assign pend_cnt = w_pend;
  assign busy     = r_busy;
  assign ovf      = r_ovf;

endmodule : pulse_pacer

`default_nettype wire

// File: tb/tb_pulse_pacer.sv
// ============================================================================
// Module      : tb_pulse_pacer
// Description : Self-checking bench for pulse_pacer (MIN_GAP=10, CNT_W=4).
//               A time-based reference model (pending count, time of last
//               launch) predicts every output each cycle; directed scenarios
//               add fixed-value checks, and a toggle synchronizer into a
//               3x slower clock counts pulses across the domain crossing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_pacer;

  localparam int MIN_GAP  = 10;
  localparam int CNT_W    = 4;
  localparam int PEND_MAX = (1 << CNT_W) - 1;
  localparam int NEVER    = -100000;

  logic             clk = 1'b0;
  logic             clk_s = 1'b0;
  logic             rst_n;
  logic             evt_in;
  logic             flush;
  logic             sig_a;
  logic [CNT_W-1:0] pend_cnt;
  logic             busy;
  logic             ovf;

  always #5  clk   = ~clk;
  always #15 clk_s = ~clk_s;

  pulse_pacer #(
    .MIN_GAP (MIN_GAP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .evt_in   (evt_in),
    .flush    (flush),
    .sig_a    (sig_a),
    .pend_cnt (pend_cnt),
    .busy     (busy),
    .ovf      (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a launch may happen once MIN_GAP cycles have elapsed
  // since the previous launch; each launch shows as a pulse one cycle later.
  int m_pend = 0;
  int m_last = NEVER;
  bit m_ovf  = 0;
  bit m_sig  = 0;
  bit m_busy = 0;

  int cyc = 0;
  int last_rise = NEVER;
  bit prev_sig = 0;
  int peak = 0;
  int rises[$];

  task automatic step(input bit e, input bit f, input bit r);
    bit launch;
    int p;
    evt_in = e;
    flush  = f;
    rst_n  = r;
    @(posedge clk);
    if (!r) begin
      m_pend = 0; m_ovf = 0; m_last = NEVER; m_sig = 0; m_busy = 0;
      last_rise = NEVER;
    end else begin
      launch = 0;
      if (f) begin
        m_pend = 0;
        m_ovf  = 0;
      end else begin
        launch = ((cyc - m_last) >= MIN_GAP) && ((m_pend > 0) || e);
        p = m_pend + int'(e) - int'(launch);
        if (p > PEND_MAX) begin
          p = PEND_MAX;
          m_ovf = 1;
        end
        m_pend = p;
      end
      if (launch) m_last = cyc;
      m_sig  = launch;
      m_busy = (((cyc + 1) - m_last) <= MIN_GAP) || (m_pend != 0);
    end
    #1;
    check_eq("sig_a", 32'(sig_a), 32'(m_sig));
    check_eq("pend_cnt", 32'(pend_cnt), 32'(m_pend));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    if (sig_a && !prev_sig) begin
      if (last_rise != NEVER)
        check_eq("spacing_ok", 32'((cyc + 1 - last_rise) >= MIN_GAP), 32'd1);
      last_rise = cyc + 1;
      rises.push_back(cyc + 1);
    end
    prev_sig = sig_a;
    if (int'(pend_cnt) > peak) peak = int'(pend_cnt);
    cyc++;
  endtask

  task automatic start_scenario(output int base);
    rises.delete();
    peak = 0;
    base = cyc;
  endtask

  // Downstream fast-to-slow toggle synchronizer, never reset.
  logic r_tgl = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   n_in = 0;
  int   n_out = 0;

  always @(posedge clk) begin
    if (sig_a === 1'b1) begin
      r_tgl <= ~r_tgl;
      n_in  <= n_in + 1;
    end
  end

  always @(posedge clk_s) begin
    s1 <= r_tgl;
    s2 <= s1;
    s3 <= s2;
    if (s2 ^ s3) n_out <= n_out + 1;
  end

  initial begin
    int base;
    int gap;
    evt_in = 1'b0;
    flush  = 1'b0;
    rst_n  = 1'b0;

    // Reset state; evt_in during reset is ignored.
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    check_eq("rst_sig_a", 32'(sig_a), 32'd0);
    check_eq("rst_pend", 32'(pend_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    step(0, 0, 1);
    check_eq("rst_no_pulse", 32'(sig_a), 32'd0);

    // Single event at cycle 5: pulse at cycle 6, busy low again at 16.
    start_scenario(base);
    for (int k = 0; k < 25; k++) begin
      step(k == 5, 0, 1);
      if (k == 14) check_eq("single_busy15", 32'(busy), 32'd1);
      if (k == 15) check_eq("single_busy16", 32'(busy), 32'd0);
    end
    check_eq("single_npulse", 32'(rises.size()), 32'd1);
    if (rises.size() >= 1) check_eq("single_t", 32'(rises[0] - base), 32'd6);

    // Burst of 4 events.
    start_scenario(base);
    for (int k = 0; k < 45; k++) step(k < 4, 0, 1);
    check_eq("burst_npulse", 32'(rises.size()), 32'd4);
    for (int i = 0; i < 4 && i < rises.size(); i++)
      check_eq("burst_t", 32'(rises[i] - base), 32'(1 + 10 * i));
    check_eq("burst_peak", 32'(peak), 32'd3);
    check_eq("burst_ovf", 32'(ovf), 32'd0);

    // Saturation: evt_in held for 20 cycles.
    start_scenario(base);
    for (int k = 0; k < 200; k++) step(k < 20, 0, 1);
    check_eq("sat_peak", 32'(peak), 32'(PEND_MAX));
    check_eq("sat_ovf", 32'(ovf), 32'd1);
    check_eq("sat_npulse", 32'(rises.size()), 32'd17);
    for (int i = 1; i < rises.size(); i++)
      check_eq("sat_spacing", 32'(rises[i] - rises[i-1]), 32'(MIN_GAP));

    // Flush mid-gap with 5 pending (ovf still set from saturation).
    start_scenario(base);
    for (int k = 0; k < 6; k++) step(1, 0, 1);
    check_eq("flush_pre_pend", 32'(pend_cnt), 32'd5);
    step(0, 1, 1);
    check_eq("flush_pend", 32'(pend_cnt), 32'd0);
    check_eq("flush_ovf", 32'(ovf), 32'd0);
    check_eq("flush_busy_gap", 32'(busy), 32'd1);
    for (int k = 0; k < 30; k++) step(0, 0, 1);
    check_eq("flush_npulse", 32'(rises.size()), 32'd1);
    check_eq("flush_idle", 32'(busy), 32'd0);

    // Reset during GAP with 3 pending.
    start_scenario(base);
    for (int k = 0; k < 4; k++) step(1, 0, 1);
    step(0, 0, 1);
    check_eq("rgap_pre_pend", 32'(pend_cnt), 32'd3);
    step(0, 0, 0);
    check_eq("rgap_sig", 32'(sig_a), 32'd0);
    check_eq("rgap_pend", 32'(pend_cnt), 32'd0);
    check_eq("rgap_busy", 32'(busy), 32'd0);
    check_eq("rgap_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 40; k++) step(0, 0, 1);
    check_eq("rgap_npulse", 32'(rises.size()), 32'd1);

    // Random sparse events, 10..50 cycles apart.
    for (int e = 0; e < 200; e++) begin
      step(1, 0, 1);
      gap = int'($urandom_range(50, 10));
      repeat (gap - 1) step(0, 0, 1);
    end

    // Random dense traffic with occasional flush.
    for (int k = 0; k < 600; k++)
      step(bit'($urandom_range(1, 0)), ($urandom_range(63, 0) == 0), 1);

    repeat (40) step(0, 0, 1);
    check_eq("sync_count", 32'(n_out), 32'(n_in));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pulse_pacer

`default_nettype wire
